// File: rtl/rv_pkg.sv
// Shared writeback types.
// XLEN / REG_ADDR_W size the register file datapath; wb_entry_t is one
// pending register write {rd, data}; lookup_t is the result of a bypass lookup.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] data;
   } lookup_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Load-result handshake between the LSU and the writeback unit.
//   lsu_valid : LSU offers a load result
//   lsu_ready : writeback queue can take it
//   lsu_rd    : destination register
//   lsu_data  : load data
// master = LSU side, slave = writeback unit side.
interface writeback_unit_if;
   import rv_pkg::*;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [REG_ADDR_W-1:0] lsu_rd;
   logic [XLEN-1:0]       lsu_data;

   modport master (output lsu_valid, output lsu_rd, output lsu_data, input lsu_ready);
   modport slave  (input lsu_valid, input lsu_rd, input lsu_data, output lsu_ready);

endinterface

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: circular queue of pending load writebacks.
//   clk, reset    : clock, synchronous active-high reset (control only)
//   push_i        : write push_entry_i at the tail (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   head_o        : oldest entry
//   count_o       : number of valid entries, 0..DEPTH
//   entries_o     : all slots re-ordered oldest first, entry_vld_o marks valid ones
module wb_fifo
   import rv_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  wb_entry_t        push_entry_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output logic [CNT_W-1:0] count_o,
   output wb_entry_t        entries_o [DEPTH],
   output logic [DEPTH-1:0] entry_vld_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      do_push  = push_i && (count_q < FULL);
      do_pop   = pop_i && (count_q != '0);
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: a slot is only ever read while count marks it valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
   end

   // Age-ordered view so the lookup can let the youngest match win.
   always_comb begin
      entry_vld_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic [SUM_W-1:0] sum;
         sum = {1'b0, rd_ptr_q} + SUM_W'(k);
         if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
         entries_o[k]   = mem_q[sum[PTR_W-1:0]];
         entry_vld_o[k] = (CNT_W'(k) < count_q);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results into a single register-file
// write port and provides bypass lookups of writes still in flight.
//   clk, reset                    : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     : ALU result, never stalled, highest priority
//   lsu (writeback_unit_if.slave) : load results, queued in wb_fifo
//   write_address/data/enable     : registered register-file write port
//   lookup_address1/2             : decode-stage source registers
//   lookup_hit1/2, lookup_data1/2 : pending-write bypass (combinational)
//   idle                          : queue empty and no write this cycle
module writeback_unit
   import rv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   writeback_unit_if.slave       lsu,
   output logic [REG_ADDR_W-1:0] write_address,
   output logic [XLEN-1:0]       write_data,
   output logic                  write_enable,
   input  logic [REG_ADDR_W-1:0] lookup_address1,
   input  logic [REG_ADDR_W-1:0] lookup_address2,
   output logic                  lookup_hit1,
   output logic                  lookup_hit2,
   output logic [XLEN-1:0]       lookup_data1,
   output logic [XLEN-1:0]       lookup_data2,
   output logic                  idle
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   wb_entry_t        head;
   wb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] entry_vld;
   logic [CNT_W-1:0] count;
   logic             push, pop;
   logic             sel_vld;
   wb_entry_t        sel;
   wb_entry_t        out_q, out_d;
   logic             we_q, we_d;
   lookup_t          lk1, lk2;

   // Oldest queue entry is scanned first so younger matches overwrite it;
   // the output stage is the oldest pending write of all.
   function automatic lookup_t lookup(input logic [REG_ADDR_W-1:0] addr,
                                      input wb_entry_t ents [DEPTH],
                                      input logic [DEPTH-1:0] vld,
                                      input logic out_we,
                                      input wb_entry_t out_ent);
      lookup_t r;
      r = '0;
      if (addr != '0) begin
         if (out_we && (out_ent.rd == addr)) begin
            r.hit  = 1'b1;
            r.data = out_ent.data;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && (ents[k].rd == addr)) begin
               r.hit  = 1'b1;
               r.data = ents[k].data;
            end
         end
      end
      return r;
   endfunction

   // Ready depends only on the registered count, so a full queue refuses a
   // push even when the head leaves on the same edge.
   assign lsu.lsu_ready = !reset && (count < FULL);
   assign push          = lsu.lsu_valid && lsu.lsu_ready;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i ({lsu.lsu_rd, lsu.lsu_data}),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .entries_o    (entries),
      .entry_vld_o  (entry_vld)
   );

   // Source select: ALU first, queue head only on ALU-idle cycles.
   always_comb begin
      sel_vld = 1'b0;
      sel     = '0;
      pop     = 1'b0;
      if (alu_valid) begin
         sel_vld = 1'b1;
         sel     = {alu_rd, alu_data};
      end else if (count != '0) begin
         sel_vld = 1'b1;
         sel     = head;
         pop     = 1'b1;
      end
      // rd==0 is consumed and presented but never strobed.
      we_d  = sel_vld && (sel.rd != '0);
      out_d = sel_vld ? sel : out_q;
   end

   // Output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q  <= 1'b0;
         out_q <= '0;
      end else begin
         we_q  <= we_d;
         out_q <= out_d;
      end
   end

   assign write_enable  = we_q;
   assign write_address = out_q.rd;
   assign write_data    = out_q.data;

   assign lk1          = lookup(lookup_address1, entries, entry_vld, we_q, out_q);
   assign lk2          = lookup(lookup_address2, entries, entry_vld, we_q, out_q);
   assign lookup_hit1  = lk1.hit;
   assign lookup_data1 = lk1.data;
   assign lookup_hit2  = lk2.hit;
   assign lookup_data2 = lk2.data;

   assign idle = (count == '0) && !we_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
   import rv_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic [REG_ADDR_W-1:0] write_address;
   logic [XLEN-1:0]       write_data;
   logic                  write_enable;
   logic [REG_ADDR_W-1:0] lookup_address1, lookup_address2;
   logic                  lookup_hit1, lookup_hit2;
   logic [XLEN-1:0]       lookup_data1, lookup_data2;
   logic                  idle;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_unit_if lsu_if ();

   writeback_unit #(.DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .alu_valid       (alu_valid),
      .alu_rd          (alu_rd),
      .alu_data        (alu_data),
      .lsu             (lsu_if.slave),
      .write_address   (write_address),
      .write_data      (write_data),
      .write_enable    (write_enable),
      .lookup_address1 (lookup_address1),
      .lookup_address2 (lookup_address2),
      .lookup_hit1     (lookup_hit1),
      .lookup_hit2     (lookup_hit2),
      .lookup_data1    (lookup_data1),
      .lookup_data2    (lookup_data2),
      .idle            (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lsu_if.lsu_valid = v;
      lsu_if.lsu_rd    = rd;
      lsu_if.lsu_data  = d;
   endtask

   initial begin
      reset           = 1'b1;
      lookup_address1 = 5'd5;
      lookup_address2 = 5'd0;
      alu(1'b0, 5'd0, 32'd0);
      ld(1'b0, 5'd0, 32'd0);
      tick();
      tick();
      chk("rst_ready_low", 32'(lsu_if.lsu_ready), 32'd0);
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_waddr", 32'(write_address), 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 32'(lsu_if.lsu_ready), 32'd1);
      chk("post_rst_idle", 32'(idle), 32'd1);
      chk("post_rst_hit5", 32'(lookup_hit1), 32'd0);

      // ALU write, one cycle latency, then hold
      lookup_address1 = 5'd3;
      alu(1'b1, 5'd3, 32'd1234);
      tick();
      alu(1'b0, 5'd0, 32'd0);
      #1;
      chk("alu_we", 32'(write_enable), 32'd1);
      chk("alu_addr", 32'(write_address), 32'd3);
      chk("alu_data", write_data, 32'd1234);
      chk("alu_out_hit", 32'(lookup_hit1), 32'd1);
      chk("alu_out_hdata", lookup_data1, 32'd1234);
      tick();
      chk("alu_we_drop", 32'(write_enable), 32'd0);
      chk("alu_hold_addr", 32'(write_address), 32'd3);
      chk("alu_hold_data", write_data, 32'd1234);
      chk("alu_nohit", 32'(lookup_hit1), 32'd0);

      // Single load, two cycle latency
      lookup_address1 = 5'd7;
      lookup_address2 = 5'd7;
      ld(1'b1, 5'd7, 32'd5678);
      #1;
      chk("ld_ready", 32'(lsu_if.lsu_ready), 32'd1);
      tick();
      ld(1'b0, 5'd0, 32'd0);
      #1;
      chk("ld_n1_we", 32'(write_enable), 32'd0);
      chk("ld_n1_hit1", 32'(lookup_hit1), 32'd1);
      chk("ld_n1_data1", lookup_data1, 32'd5678);
      chk("ld_n1_hit2", 32'(lookup_hit2), 32'd1);
      chk("ld_n1_idle", 32'(idle), 32'd0);
      tick();
      chk("ld_n2_we", 32'(write_enable), 32'd1);
      chk("ld_n2_addr", 32'(write_address), 32'd7);
      chk("ld_n2_data", write_data, 32'd5678);
      chk("ld_n2_hit1", 32'(lookup_hit1), 32'd1);
      chk("ld_n2_data2", lookup_data2, 32'd5678);
      tick();
      chk("ld_done_we", 32'(write_enable), 32'd0);
      chk("ld_done_hit", 32'(lookup_hit1), 32'd0);
      chk("ld_done_miss_data", lookup_data1, 32'd0);
      chk("ld_done_idle", 32'(idle), 32'd1);

      // ALU every cycle while three loads are offered
      lookup_address1 = 5'd0;
      lookup_address2 = 5'd0;
      alu(1'b1, 5'd20, 32'd200);
      ld(1'b1, 5'd10, 32'd100);
      #1;
      chk("bp_rdy0", 32'(lsu_if.lsu_ready), 32'd1);
      tick();
      chk("bp_w0_addr", 32'(write_address), 32'd20);
      alu(1'b1, 5'd21, 32'd201);
      ld(1'b1, 5'd11, 32'd101);
      #1;
      chk("bp_rdy1", 32'(lsu_if.lsu_ready), 32'd1);
      tick();
      chk("bp_w1_data", write_data, 32'd201);
      alu(1'b1, 5'd22, 32'd202);
      ld(1'b1, 5'd12, 32'd102);
      #1;
      chk("bp_rdy2_full", 32'(lsu_if.lsu_ready), 32'd0);
      tick();
      chk("bp_w2_we", 32'(write_enable), 32'd1);
      chk("bp_w2_data", write_data, 32'd202);
      alu(1'b0, 5'd0, 32'd0);
      #1;
      chk("bp_rdy3_full", 32'(lsu_if.lsu_ready), 32'd0);
      tick();
      chk("bp_d0_addr", 32'(write_address), 32'd10);
      chk("bp_d0_data", write_data, 32'd100);
      chk("bp_rdy4", 32'(lsu_if.lsu_ready), 32'd1);
      tick();
      ld(1'b0, 5'd0, 32'd0);
      chk("bp_d1_addr", 32'(write_address), 32'd11);
      chk("bp_d1_data", write_data, 32'd101);
      tick();
      chk("bp_d2_we", 32'(write_enable), 32'd1);
      chk("bp_d2_addr", 32'(write_address), 32'd12);
      chk("bp_d2_data", write_data, 32'd102);
      tick();
      chk("bp_end_we", 32'(write_enable), 32'd0);
      chk("bp_end_idle", 32'(idle), 32'd1);

      // rd==0 from both sources
      lookup_address1 = 5'd0;
      alu(1'b1, 5'd0, 32'd55);
      ld(1'b1, 5'd0, 32'd66);
      tick();
      alu(1'b0, 5'd0, 32'd0);
      ld(1'b0, 5'd0, 32'd0);
      #1;
      chk("r0_alu_we", 32'(write_enable), 32'd0);
      chk("r0_hit_q", 32'(lookup_hit1), 32'd0);
      chk("r0_queued", 32'(idle), 32'd0);
      tick();
      chk("r0_lsu_we", 32'(write_enable), 32'd0);
      chk("r0_hit_out", 32'(lookup_hit1), 32'd0);
      tick();
      chk("r0_idle", 32'(idle), 32'd1);

      // Two loads to rd=4 held by ALU traffic, youngest wins, reset mid-drain
      lookup_address1 = 5'd4;
      alu(1'b1, 5'd9, 32'd9);
      ld(1'b1, 5'd4, 32'd11);
      tick();
      ld(1'b1, 5'd4, 32'd22);
      tick();
      alu(1'b0, 5'd0, 32'd0);
      ld(1'b0, 5'd0, 32'd0);
      #1;
      chk("r4_full", 32'(lsu_if.lsu_ready), 32'd0);
      chk("r4_hit", 32'(lookup_hit1), 32'd1);
      chk("r4_young", lookup_data1, 32'd22);
      tick();
      chk("r4_drain_we", 32'(write_enable), 32'd1);
      chk("r4_drain_data", write_data, 32'd11);
      chk("r4_drain_look", lookup_data1, 32'd22);
      reset = 1'b1;
      tick();
      chk("mid_rst_we", 32'(write_enable), 32'd0);
      chk("mid_rst_addr", 32'(write_address), 32'd0);
      chk("mid_rst_data", write_data, 32'd0);
      chk("mid_rst_ready", 32'(lsu_if.lsu_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst_idle", 32'(idle), 32'd1);
      chk("mid_rst_ready1", 32'(lsu_if.lsu_ready), 32'd1);
      chk("mid_rst_nohit", 32'(lookup_hit1), 32'd0);
      tick();
      chk("mid_rst_we1", 32'(write_enable), 32'd0);
      tick();
      chk("mid_rst_we2", 32'(write_enable), 32'd0);
      chk("mid_rst_idle2", 32'(idle), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have one clock `clk`; reset is synchronous and active-high, named `reset`.
REQ-002 SHALL have parameter DEPTH, default 2: LSU result queue depth, legal range 2..8.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  sync active-high reset
- alu_valid  in  1  ALU result present this cycle; never back-pressured
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  queue can accept a load result
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- write_address  out  5  register file write address
- write_data  out  32  register file write data
- write_enable  out  1  register file write strobe
- lookup_address1, lookup_address2  in  5  decode-stage source registers
- lookup_hit1, lookup_hit2  out  1  pending write to that register exists
- lookup_data1, lookup_data2  out  32  youngest pending value for that register
- idle  out  1  queue empty and write_enable low

Function
REQ-004 SHALL issue at most one register file write per cycle.
REQ-005 SHALL accept a load result on a cycle when lsu_valid and lsu_ready are both high, pushing {lsu_rd, lsu_data} into the FIFO at that edge.
REQ-006 lsu_ready SHALL be a function of the registered count only: high iff count < DEPTH; no push while full, even on a simultaneous pop.
REQ-007 Issue priority SHALL be: alu_valid over queue head; the head pops at an edge only when alu_valid is low and count > 0.
REQ-008 Write outputs SHALL be registered: the source selected in cycle N drives write_address/write_data in cycle N+1.
REQ-009 write_enable SHALL be high in cycle N+1 iff a source was selected in cycle N and its rd != 0; an rd==0 entry is consumed but never written.
REQ-010 When nothing is selected, write_enable SHALL be 0 and write_address/write_data SHALL hold their previous values.
REQ-011 Minimum load latency SHALL be 2 cycles: accepted at edge N, written to the register file at edge N+2 with write_enable high during cycle N+2, provided alu_valid is low in cycle N+1.
REQ-012 ALU latency SHALL be 1 cycle: alu_valid in cycle N gives write_enable during cycle N+1.
REQ-013 Queue pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never under- or overflow.
REQ-014 Lookup SHALL be combinational.
- hit iff address != 0 and it matches a valid queue entry or the output stage with write_enable high.
- data priority: youngest matching queue entry, then older queue entries, then the output stage.
- on a miss, data SHALL be 0.
REQ-015 A push and a pop in the same cycle SHALL leave count unchanged; the pushed entry SHALL be visible to lookup from the next cycle.
REQ-016 Program ordering between ALU and LSU writes to the same register is the issue logic's responsibility; this block SHALL NOT reorder within the queue.

Reset
REQ-017 While reset is high at an edge: count, read pointer and write pointer SHALL clear to 0, and write_enable, write_address and write_data SHALL clear to 0.
REQ-018 lsu_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.
REQ-019 Reset asserted mid-operation SHALL discard all queued entries without issuing any write.
REQ-020 idle SHALL be 1 after reset.

Structure
REQ-021 The shared package rv_pkg SHALL hold XLEN=32, REG_ADDR_W=5 and typedef wb_entry_t {rd, data}.
REQ-022 The queue SHALL be a sub-module wb_fifo (DEPTH, wb_entry_t) exposing push, pop, head, count, and all entries for lookup.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset, then idle: write_enable=0, lsu_ready=1, idle=1, lookup_hit1=0 for address 5.
- alu_valid with rd=3, data=1234 at cycle 0: write_enable=1, address 3, data 1234 in cycle 1.
- Load rd=7, data=5678 with ALU idle: written in cycle N+2; lookup_hit1=1 and data=5678 for address 7 during cycles N+1..N+2.
- ALU valid every cycle while 3 loads are offered (DEPTH=2): lsu_ready drops after 2 accepts, no writes are lost, and loads drain in FIFO order once ALU stops.
- Writes to rd=0 from both ALU and LSU: write_enable never asserted; lookup for address 0 never hits.
- Queue holds rd=4 (data 11 then 22); lookup for address 4 returns 22; reset mid-drain clears count and leaves no write_enable after reset.
